// File: rtl/game_tick_sched.sv
// Game-speed scheduler: single-cycle tick enable with run/pause/step
// sequencing and rate changes committed only on tick boundaries.
module game_tick_sched #(
  parameter int unsigned BASE_CNT = 12_500_000,
  parameter int unsigned CNT_W    = 32,
  parameter logic [1:0]  RST_RATE = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        step,
  input  logic        faster,
  input  logic        slower,
  input  logic        auto_up,
  output logic        tick,
  output logic [1:0]  rate_cur,
  output logic [1:0]  rate_pend,
  output logic [1:0]  state,
  output logic [15:0] tick_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;
  logic [1:0]       r_rate_cur;
  logic [1:0]       r_rate_pend;
  logic [15:0]      r_tick_count;
  logic             w_bnd;
  logic             w_adv;
  logic             w_up;

  assign w_limit = (CNT_W'(BASE_CNT) << r_rate_cur)
                 - CNT_W'(1);
  assign w_bnd   = (r_state == S_RUN) && (r_cnt == w_limit);
  // boundary or step cycle: tick, commit rate, bump count
  assign w_adv   = w_bnd || (r_state == S_STEP);
  assign w_up    = faster | auto_up;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_next = S_RUN;
        S_RUN:   if (pause) w_next = S_PAUSE;
        S_PAUSE: begin
          if (pause)     w_next = S_RUN;
          else if (step) w_next = S_STEP;
        end
        S_STEP:  w_next = S_PAUSE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tick = 1'b0;
    if (!rst && !stop) tick = w_adv;
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  r_cnt <= '0;
        S_RUN: begin
          if (w_bnd)      r_cnt <= '0;
          else if (pause) r_cnt <= r_cnt;
          else            r_cnt <= r_cnt + CNT_W'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate_cur   <= RST_RATE;
      r_tick_count <= '0;
    end else if (!stop) begin
      if ((r_state == S_IDLE) || w_adv)
        r_rate_cur <= r_rate_pend;
      if ((r_state == S_IDLE) && start)
        r_tick_count <= '0;
      else if (w_adv)
        r_tick_count <= r_tick_count + 16'd1;
    end
  end

  // saturating arbitration; opposing requests cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate_pend <= RST_RATE;
    end else if (w_up && !slower) begin
      if (r_rate_pend != 2'd0)
        r_rate_pend <= r_rate_pend - 2'd1;
    end else if (slower && !w_up) begin
      if (r_rate_pend != 2'd3)
        r_rate_pend <= r_rate_pend + 2'd1;
    end
  end

  assign rate_cur   = r_rate_cur;
  assign rate_pend  = r_rate_pend;
  assign state      = r_state;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_game_tick_sched.sv
// Bench for game_tick_sched: expected ticks queued by stimulus,
// checked by an independent monitor on the falling edge.
module tb_game_tick_sched;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, step;
  logic        faster, slower, auto_up;
  logic        tick;
  logic [1:0]  rate_cur, rate_pend, state;
  logic [15:0] tick_count;

  typedef struct {
    int cyc;
    int tc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_tick = 1'b0;
  int   t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_tick_sched #(
    .BASE_CNT(4),
    .CNT_W(32),
    .RST_RATE(2'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .step(step),
    .faster(faster),
    .slower(slower),
    .auto_up(auto_up),
    .tick(tick),
    .rate_cur(rate_cur),
    .rate_pend(rate_pend),
    .state(state),
    .tick_count(tick_count)
  );

  task automatic chk(input string name,
                     input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic adv(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_tick(input int c, input int tc);
    exp_t e;
    e.cyc = c;
    e.tc  = tc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tick === 1'b1) begin
      chk("tick_gap", int'(prev_tick), 0);
      if (q.size() == 0) begin
        chk("unexpected_tick_cyc", cyc, -1);
      end else begin
        e = q.pop_front();
        chk("tick_cyc", cyc, e.cyc);
        chk("tick_count_at_tick", int'(tick_count), e.tc);
      end
    end
    prev_tick = tick;
  end

  initial begin
    rst = 1; start = 0; stop = 0; pause = 0; step = 0;
    faster = 0; slower = 0; auto_up = 0;
    adv(3);
    chk("rst_state", int'(state), 0);
    chk("rst_rate_cur", int'(rate_cur), 2);
    chk("rst_rate_pend", int'(rate_pend), 2);
    chk("rst_tick_count", int'(tick_count), 0);
    chk("rst_tick", int'(tick), 0);
    rst = 0;
    adv();

    // periodic ticks at ratio 4
    start = 1; adv(); start = 0;
    t = cyc;
    chk("run_state", int'(state), 1);
    expect_tick(t + 15, 0);
    expect_tick(t + 31, 1);
    expect_tick(t + 47, 2);
    adv(48);
    chk("run_count3", int'(tick_count), 3);
    adv(6);

    // faster mid-period commits at the boundary
    faster = 1; adv(); faster = 0;
    t = cyc;
    chk("fast_pend", int'(rate_pend), 1);
    chk("fast_cur_hold", int'(rate_cur), 2);
    expect_tick(t + 8, 3);
    expect_tick(t + 16, 4);
    expect_tick(t + 24, 5);
    adv(9);
    chk("fast_cur_new", int'(rate_cur), 1);
    adv(16);
    chk("fast_count", int'(tick_count), 6);

    // saturation both ways, opposing requests cancel
    faster = 1; adv();
    faster = 0; auto_up = 1; adv();
    auto_up = 0; faster = 1; adv();
    faster = 0;
    t = cyc;
    chk("sat_lo_pend", int'(rate_pend), 0);
    expect_tick(t + 4, 6);
    expect_tick(t + 8, 7);
    expect_tick(t + 40, 8);
    adv(5);
    chk("sat_lo_cur", int'(rate_cur), 0);
    slower = 1; adv(5); slower = 0;
    chk("sat_hi_pend", int'(rate_pend), 3);
    chk("sat_hi_cur", int'(rate_cur), 3);
    faster = 1; slower = 1; adv();
    faster = 0; slower = 0;
    chk("cancel_pend", int'(rate_pend), 3);
    adv(30);
    chk("slow_count", int'(tick_count), 9);
    faster = 1; adv(); faster = 0;
    chk("back_pend", int'(rate_pend), 2);
    chk("back_cur_hold", int'(rate_cur), 3);
    expect_tick(t + 72, 9);
    adv(31);
    chk("back_cur", int'(rate_cur), 2);
    chk("back_count", int'(tick_count), 10);

    // pause at cnt=5, single step, resume
    t = cyc;
    adv(5);
    pause = 1; adv(); pause = 0;
    chk("pause_state", int'(state), 2);
    adv(10);
    chk("pause_count", int'(tick_count), 10);
    expect_tick(t + 17, 10);
    step = 1; adv(); step = 0;
    chk("step_state", int'(state), 3);
    adv();
    chk("step_back", int'(state), 2);
    chk("step_count", int'(tick_count), 11);
    pause = 1; step = 1; adv();
    pause = 0; step = 0;
    chk("resume_state", int'(state), 1);
    expect_tick(t + 29, 11);
    adv(11);
    chk("resume_count", int'(tick_count), 12);

    // stop on the boundary cycle
    adv(15);
    stop = 1;
    #1;
    chk("stop_tick", int'(tick), 0);
    adv(); stop = 0;
    chk("stop_state", int'(state), 0);
    chk("stop_count_keep", int'(tick_count), 12);
    pause = 1; adv(); pause = 0;
    step = 1; adv(); step = 0;
    chk("idle_inert", int'(state), 0);
    start = 1; adv(); start = 0;
    t = cyc;
    chk("restart_state", int'(state), 1);
    chk("restart_count", int'(tick_count), 0);
    expect_tick(t + 15, 0);
    adv(16);
    faster = 1; adv(2); faster = 0;
    adv(7);
    chk("pre_rst_pend", int'(rate_pend), 0);

    // reset mid-run at cnt=9
    rst = 1; adv(); rst = 0;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_cur", int'(rate_cur), 2);
    chk("mid_rst_pend", int'(rate_pend), 2);
    chk("mid_rst_count", int'(tick_count), 0);
    pause = 1; adv(); pause = 0;
    step = 1; adv(); step = 0;
    adv(20);
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_count", int'(tick_count), 0);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
